// File: rtl/uart_pkg.sv
// uart_pkg: shared UART defaults and receiver FSM state encoding
package uart_pkg;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_CLKS_PER_BIT = 16;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop single-bit synchronizer with selectable reset value
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk or posedge rst)
        if (rst) {q, meta} <= {2{RESET_VAL}};
        else {q, meta} <= {meta, d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1-style UART receiver, midpoint sampling, valid/ready output
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ser_in,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] MID_CNT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] END_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);
    rx_state_t state, state_nxt;
    logic rxs, mid, bit_end, clr_cnt, sample, load, bad_stop;
    logic [CW-1:0] bit_cnt;
    logic [IW-1:0] data_idx;
    logic [DATA_WIDTH-1:0] shift_reg;
    sync_2ff #(.RESET_VAL(1'b1)) u_sync (.clk(clk), .rst(rst), .d(ser_in), .q(rxs));
    assign mid = bit_cnt == MID_CNT;
    assign bit_end = bit_cnt == END_CNT;
    assign busy = state != IDLE;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nxt;
    // Re-zeroing the timer at the start-bit midpoint puts every later end-of-count on a bit midpoint.
    always_comb begin
        state_nxt = state;
        clr_cnt = 1'b0;
        sample = 1'b0;
        load = 1'b0;
        bad_stop = 1'b0;
        case (state)
            IDLE: begin
                clr_cnt = 1'b1;
                if (!rxs) state_nxt = START;
            end
            START: if (mid) begin
                clr_cnt = 1'b1;
                state_nxt = rxs ? IDLE : DATA;
            end
            DATA: if (bit_end) begin
                sample = 1'b1;
                if (data_idx == LAST_IDX) state_nxt = STOP;
            end
            STOP: if (bit_end) begin
                load = rxs;
                bad_stop = !rxs;
                state_nxt = rxs ? IDLE : BREAK;
            end
            BREAK: if (rxs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            bit_cnt <= '0;
            data_idx <= '0;
            shift_reg <= '0;
            rx_data <= '0;
            rx_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun <= 1'b0;
        end else begin
            bit_cnt <= (clr_cnt || bit_end) ? '0 : bit_cnt + 1'b1;
            data_idx <= state != DATA ? '0 : sample ? data_idx + 1'b1 : data_idx;
            if (sample) shift_reg <= {rxs, shift_reg[DATA_WIDTH-1:1]};
            if (load) rx_data <= shift_reg;
            rx_valid <= load || (rx_valid && !rx_ready);
            frame_err <= bad_stop;
            overrun <= load && rx_valid && !rx_ready;
        end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: vector table plus corner-case sequences for uart_rx, scoreboard on accepted words
module tb_uart_rx;
    import uart_pkg::*;
    localparam int CPB = 16;
    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_words;
        int         exp_ferr;
    } vec_t;
    logic clk = 1'b0, rst = 1'b1, ser_in = 1'b1, rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic rx_valid, frame_err, overrun, busy;
    int checks = 0, failures = 0, cyc = 0;
    int n_vcyc = 0, n_rise = 0, n_ferr = 0, n_ovr = 0, n_both = 0, last_rise = 0;
    logic prev_valid = 1'b0;
    logic [7:0] exp_q[$];
    int rise_q[$];
    vec_t vecs[5];

    uart_rx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .ser_in(ser_in), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_latency(input int lat);
        checks++;
        if (lat < 153 || lat > 155) begin
            failures++;
            $display("FAIL latency: got %0d expected 154 +-1", lat);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) n_vcyc++;
            if (rx_valid && !prev_valid) begin
                n_rise++;
                last_rise = cyc;
                rise_q.push_back(cyc);
            end
            if (frame_err) n_ferr++;
            if (overrun) n_ovr++;
            if (frame_err && overrun) n_both++;
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got %0h expected none", rx_data);
                end else check("rx_data", rx_data, exp_q.pop_front());
            end
        end
        prev_valid = rx_valid;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        ser_in = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            ser_in = d[i];
            tick(CPB);
        end
        ser_in = stop;
        tick(CPB);
    endtask

    initial begin
        int v0, r0, f0, o0, start;
        vecs[0] = '{8'hA5, 1'b1, 1, 0};
        vecs[1] = '{8'h00, 1'b1, 1, 0};
        vecs[2] = '{8'hFF, 1'b1, 1, 0};
        vecs[3] = '{8'h3C, 1'b0, 0, 1};
        vecs[4] = '{8'h81, 1'b1, 1, 0};

        tick(3);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        tick(5);

        for (int k = 0; k < 5; k++) begin
            v0 = n_vcyc;
            f0 = n_ferr;
            if (vecs[k].stop) exp_q.push_back(vecs[k].data);
            start = cyc;
            send_frame(vecs[k].data, vecs[k].stop);
            ser_in = 1'b1;
            tick(20);
            check("vec_valid_cycles", n_vcyc - v0, vecs[k].exp_words);
            check("vec_frame_err", n_ferr - f0, vecs[k].exp_ferr);
            check("vec_idle", busy, 0);
            if (vecs[k].stop) check_latency(last_rise - start);
        end

        r0 = n_rise;
        f0 = n_ferr;
        ser_in = 1'b0;
        tick(4);
        check("glitch_busy", busy, 1);
        tick(1);
        ser_in = 1'b1;
        tick(40);
        check("glitch_idle", busy, 0);
        check("glitch_no_valid", n_rise - r0, 0);
        check("glitch_no_ferr", n_ferr - f0, 0);

        r0 = n_rise;
        f0 = n_ferr;
        send_frame(8'h3C, 1'b0);
        tick(40);
        check("break_state", dut.state, BREAK);
        check("break_busy", busy, 1);
        ser_in = 1'b1;
        tick(5);
        check("break_exit", busy, 0);
        check("break_one_ferr", n_ferr - f0, 1);
        check("break_no_valid", n_rise - r0, 0);

        rx_ready = 1'b0;
        o0 = n_ovr;
        f0 = n_ferr;
        exp_q.push_back(8'h22);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        tick(10);
        check("ovr_pulse", n_ovr - o0, 1);
        check("ovr_no_ferr", n_ferr - f0, 0);
        check("ovr_data", rx_data, 8'h22);
        check("ovr_valid_held", rx_valid, 1);
        rx_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ovr_valid_drop", rx_valid, 0);
        tick(5);

        r0 = n_rise;
        ser_in = 1'b0;
        tick(CPB);
        ser_in = 1'b1;
        tick(4 * CPB + 8);
        rst = 1'b1;
        #1;
        check("midrst_rx_data", rx_data, 0);
        check("midrst_rx_valid", rx_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_frame_err", frame_err, 0);
        check("midrst_overrun", overrun, 0);
        tick(2);
        rst = 1'b0;
        tick(20);
        check("midrst_no_retrigger", busy, 0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        tick(10);
        check("midrst_next_word", n_rise - r0, 1);

        rise_q.delete();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h55);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        tick(20);
        check("b2b_count", rise_q.size(), 3);
        if (rise_q.size() == 3) begin
            check("b2b_gap1", rise_q[1] - rise_q[0], 160);
            check("b2b_gap2", rise_q[2] - rise_q[1], 160);
        end

        check("scoreboard_empty", exp_q.size(), 0);
        check("ferr_ovr_exclusive", n_both, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver that accepts 8N1-style frames on an asynchronous serial input and presents each received word on a valid/ready handshake. It is the receive half of the uart2ahb bridge, paired with `uart_tx`. It feeds the command decoder that turns host bytes into AHB transactions. The bit period is a fixed number of system clocks, and each bit is sampled once, at its midpoint.

## Interface
Parameters:
- `DATA_WIDTH`, 8: data bits per frame, LSB first.
- `CLKS_PER_BIT`, 16: system clocks per serial bit; must be at least 4.

Ports:
- `clk`, input, 1: system clock. All logic is on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset (already decided).
- `ser_in`, input, 1: UART line, asynchronous to `clk`; idles high.
- `rx_data`, output, DATA_WIDTH: received word; stable while `rx_valid` is high.
- `rx_valid`, output, 1: a word is held and available.
- `rx_ready`, input, 1: consumer accepts the word. A transfer occurs on any cycle where `rx_valid` and `rx_ready` are both high.
- `frame_err`, output, 1: one-cycle pulse when a stop bit is sampled low.
- `overrun`, output, 1: one-cycle pulse when a word completes while the previous word is still unaccepted.
- `busy`, output, 1: high whenever the FSM is not in IDLE.

## Operation
- **Synchronizer:** `ser_in` passes through a 2-flop synchronizer, reset to 1. The FSM sees only the synchronized `rxs`.
- **Bit timer:** `bit_cnt` counts 0..CLKS_PER_BIT-1 and wraps. `mid` = (`bit_cnt` == CLKS_PER_BIT/2 - 1). `end` = (`bit_cnt` == CLKS_PER_BIT-1).
- **FSM states and transitions:**
  - IDLE → START when `rxs` == 0; `bit_cnt` clears.
  - START, at `mid`:
    - if `rxs` == 0, go to DATA and clear `bit_cnt` so that later samples land on bit midpoints;
    - if `rxs` == 1, the low was a glitch; return to IDLE with no error.
  - DATA, at each `end`:
    - sample `rxs` into `shift_reg[DATA_WIDTH-1]`, shifting right;
    - `data_idx` counts 0..DATA_WIDTH-1; after the last bit, go to STOP.
  - STOP, at `end`, which is the stop-bit midpoint:
    - `rxs` == 1: the word is good. Load `rx_data` and set `rx_valid`; if `rx_valid` was already high and not being accepted this cycle, pulse `overrun`. Go to IDLE.
    - `rxs` == 0: pulse `frame_err`, discard the word, and go to BREAK.
  - BREAK → IDLE once `rxs` == 1. A held-low line never retriggers START.
- **Overrun policy:** the new word overwrites `rx_data`; the old word is lost, and `rx_valid` stays high.
- **Handshake:** `rx_valid` clears on the cycle after a transfer, unless a new word loads on that same edge. Load wins, and no overrun is flagged because the old word was accepted.
- `rx_ready` may be held high permanently.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0; FSM in IDLE; synchronizer flops at 1.
- Start-bit validation occurs CLKS_PER_BIT/2 clocks after the falling edge is seen on `rxs`.
- `rx_valid` rises on the `clk` edge that samples the stop-bit midpoint.
- Total latency from the `ser_in` falling edge to `rx_valid` is 2 + CLKS_PER_BIT/2 + (DATA_WIDTH+1)·CLKS_PER_BIT clocks, ±1 for synchronizer phase.
  - Default parameters: 2 + 8 + 144 = 154 clocks.
- Back-to-back frames: the next start edge may appear immediately after the stop-bit midpoint, and is detected from IDLE with no dead cycle.
- `frame_err` and `overrun` are never high in the same cycle.
- Asserting `rst` mid-frame returns all state to reset values immediately. The next frame is received only after a new falling edge seen in IDLE.
- Counter widths: `bit_cnt` is $clog2(CLKS_PER_BIT) bits; `data_idx` is $clog2(DATA_WIDTH) bits.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum (IDLE, START, DATA, STOP, BREAK);
  - default `DATA_WIDTH` and `CLKS_PER_BIT` constants, also used by `uart_tx`.
- One sub-module, `sync_2ff`: a generic 2-flop bit synchronizer with a reset-value parameter, reusable in the bridge.
- Everything else is flat in `uart_rx`.

## Test plan
All scenarios use the default parameters.
- **Single frame:** send 0xA5 (LSB first) with `rx_ready`=1 → `rx_data`=0xA5 and `rx_valid` high for exactly 1 cycle, 154±1 clocks after the start edge; `frame_err`=0.
- **Glitch rejection:** drive `ser_in` low for 5 clocks, then high → FSM returns to IDLE; no `rx_valid`, no `frame_err`.
- **Framing error:** send 0x3C with the stop bit low, then hold the line low 40 clocks → one `frame_err` pulse, no `rx_valid`, FSM stays in BREAK until the line goes high.
- **Overrun:** `rx_ready`=0; send 0x11 then 0x22 back-to-back → after the second frame, `overrun` pulses once, `rx_data`=0x22 and `rx_valid` stays high. Raising `rx_ready` transfers 0x22, and `rx_valid` drops the next cycle.
- **Reset mid-frame:** assert `rst` during data bit 4 of 0xFF → all outputs return to 0 at once. A following frame of 0x5A is received correctly as 0x5A.
- **Back-to-back stream:** 0x00, 0xFF, 0x55 with no idle gap and `rx_ready`=1 → three `rx_valid` pulses with those values, in order, spaced 160 clocks apart.
